dm_trace_mem: RTL and testbench

DM_TRACE_MEM -- requirements
Module: dm_trace_mem

---
 rtl/dm_pkg.sv | 26 ++
 rtl/dm_trace_fifo.sv | 58 +++++
 rtl/dm_trace_mem.sv | 121 ++++++++++++
 tb/tb_dm_trace_mem.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared types, constants and byte-merge helper for the trace memory
package dm_pkg;

  localparam int BYTE_EN_W = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_entry_t;

  // Enabled lanes take the new byte, disabled lanes keep the stored byte.
  function automatic logic [31:0] byte_merge(
    input logic [31:0]          old_word,
    input logic [31:0]          new_word,
    input logic [BYTE_EN_W-1:0] byteen
  );
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < BYTE_EN_W; i++) begin
      if (byteen[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dm_trace_fifo.sv
// rtl/dm_trace_fifo.sv - write-trace FIFO, no fall-through, push accepted when not full or popping
module dm_trace_fifo
  import dm_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  trace_entry_t push_data_i,
  output logic         full_o,
  input  logic         pop_i,
  output logic         valid_o,
  output trace_entry_t head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  trace_entry_t store_q [DEPTH];
  logic         empty;
  logic         do_pop;
  logic         do_push;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign valid_o = !empty;
  assign head_o  = store_q[rd_ptr_q[AW-1:0]];
  assign do_pop  = pop_i && !empty;
  // A pop frees the head slot at the same edge, so a full FIFO can still accept.
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer next-state; the extra MSB separates full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (do_push) store_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/dm_trace_mem.sv
// rtl/dm_trace_mem.sv - byte-writable data memory with range check and write-trace capture
module dm_trace_mem
  import dm_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          READ_LATENCY = 0,
  parameter int          TRACE_DEPTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          m_data_addr,
  input  logic [31:0]          m_data_wdata,
  input  logic [BYTE_EN_W-1:0] m_data_byteen,
  input  logic [31:0]          m_inst_addr,
  output logic [31:0]          m_data_rdata,
  output logic                 range_err,
  output logic                 trace_valid,
  input  logic                 trace_ready,
  output logic [31:0]          trace_pc,
  output logic [31:0]          trace_addr,
  output logic [31:0]          trace_data,
  output logic                 trace_overflow,
  output logic [15:0]          trace_drop_cnt
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LO    = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI    = LO + (33'(DEPTH_WORDS) << 2);

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             wr_en;
  logic [31:0]      rd_word;
  logic [31:0]      merged;
  trace_entry_t     push_entry;
  trace_entry_t     head;
  logic             trace_full;
  logic             trace_pop;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  // Compare in 33 bits so a window ending at 4 GiB does not wrap.
  assign in_range = ({1'b0, m_data_addr} >= LO) && ({1'b0, m_data_addr} < HI);
  assign idx      = IDX_W'((m_data_addr - BASE_ADDR) >> 2);
  assign wr_en    = !reset && in_range && (|m_data_byteen);
  assign rd_word  = in_range ? mem_q[idx] : 32'h0;
  assign merged   = byte_merge(mem_q[idx], m_data_wdata, m_data_byteen);

  // Every cycle presents an access, so any out-of-range address flags an error.
  assign range_err = !reset && !in_range;

  // Memory array: cleared wholesale by reset, otherwise lane-merged writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'h0;
    end else if (wr_en) begin
      mem_q[idx] <= merged;
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_rd_reg
      logic [31:0] rdata_q;
      // Registered read captures the pre-write word of the current cycle.
      always_ff @(posedge clk) begin
        if (reset) rdata_q <= 32'h0;
        else       rdata_q <= rd_word;
      end
      assign m_data_rdata = rdata_q;
    end else begin : g_rd_comb
      assign m_data_rdata = rd_word;
    end
  endgenerate

  assign push_entry = '{pc: m_inst_addr, addr: {m_data_addr[31:2], 2'b00}, data: merged};
  assign trace_pop  = trace_valid && trace_ready;

  dm_trace_fifo #(
    .DEPTH(TRACE_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (wr_en),
    .push_data_i(push_entry),
    .full_o     (trace_full),
    .pop_i      (trace_pop),
    .valid_o    (trace_valid),
    .head_o     (head)
  );

  assign trace_pc   = head.pc;
  assign trace_addr = head.addr;
  assign trace_data = head.data;

  // A write meeting a full FIFO with no pop is dropped and counted.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (wr_en && trace_full && !trace_pop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= 16'h0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign trace_overflow = overflow_q;
  assign trace_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_dm_trace_mem.sv
// tb/tb_dm_trace_mem.sv - directed self-checking bench for dm_trace_mem
module tb_dm_trace_mem;

  logic        clk;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic        trace_ready;

  logic [31:0] rdata0, rdata1;
  logic        rerr0, rerr1;
  logic        tv0, tv1;
  logic [31:0] tpc0, tpc1, taddr0, taddr1, tdata0, tdata1;
  logic        tovf0, tovf1;
  logic [15:0] tdrop0, tdrop1;

  int n_cmp = 0;
  int n_bad = 0;

  dm_trace_mem #(
    .DEPTH_WORDS(4096), .BASE_ADDR(32'h0), .READ_LATENCY(0), .TRACE_DEPTH(8)
  ) u_dut0 (
    .clk(clk), .reset(reset), .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr), .m_data_rdata(rdata0),
    .range_err(rerr0), .trace_valid(tv0), .trace_ready(trace_ready), .trace_pc(tpc0),
    .trace_addr(taddr0), .trace_data(tdata0), .trace_overflow(tovf0), .trace_drop_cnt(tdrop0)
  );

  dm_trace_mem #(
    .DEPTH_WORDS(4096), .BASE_ADDR(32'h0), .READ_LATENCY(1), .TRACE_DEPTH(8)
  ) u_dut1 (
    .clk(clk), .reset(reset), .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr), .m_data_rdata(rdata1),
    .range_err(rerr1), .trace_valid(tv1), .trace_ready(trace_ready), .trace_pc(tpc1),
    .trace_addr(taddr1), .trace_data(tdata1), .trace_overflow(tovf1), .trace_drop_cnt(tdrop1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] pc, input logic rdy);
    m_data_addr   = a;
    m_data_wdata  = d;
    m_data_byteen = be;
    m_inst_addr   = pc;
    trace_ready   = rdy;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(32'h4000, 32'h0, 4'h0, 32'h0, 1'b0);
    check_eq("reset_range_err", {31'b0, rerr0}, 32'h0);
    tick;
    tick;
    reset = 1'b0;
    drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    check_eq("reset_valid", {31'b0, tv0}, 32'h0);
    check_eq("reset_ovf", {31'b0, tovf0}, 32'h0);
    check_eq("reset_drop", {16'b0, tdrop0}, 32'h0);
    check_eq("reset_rdata0", rdata0, 32'h0);
    check_eq("reset_rdata1", rdata1, 32'h0);

    // Byte merge
    drive(32'h10, 32'h11223344, 4'hF, 32'h100, 1'b0);
    check_eq("bm_prewrite", rdata0, 32'h0);
    tick;
    drive(32'h12, 32'hAABBCCDD, 4'b0100, 32'h104, 1'b0);
    check_eq("bm_rd_mid", rdata0, 32'h11223344);
    check_eq("bm_valid", {31'b0, tv0}, 32'h1);
    tick;
    drive(32'h10, 32'h0, 4'h0, 32'h0, 1'b1);
    check_eq("bm_rd", rdata0, 32'h11BB3344);
    check_eq("bm_e0_pc", tpc0, 32'h100);
    check_eq("bm_e0_addr", taddr0, 32'h10);
    check_eq("bm_e0_data", tdata0, 32'h11223344);
    tick;
    drive(32'h10, 32'h0, 4'h0, 32'h0, 1'b1);
    check_eq("bm_rd1", rdata1, 32'h11BB3344);
    check_eq("bm_e1_pc", tpc0, 32'h104);
    check_eq("bm_e1_addr", taddr0, 32'h10);
    check_eq("bm_e1_data", tdata0, 32'h11BB3344);
    check_eq("bm_e1_data_l1", tdata1, 32'h11BB3344);
    tick;
    drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    check_eq("bm_drained", {31'b0, tv0}, 32'h0);

    // Range
    drive(32'h4000, 32'h12345678, 4'hF, 32'h400, 1'b0);
    check_eq("rg_err", {31'b0, rerr0}, 32'h1);
    check_eq("rg_err_l1", {31'b0, rerr1}, 32'h1);
    check_eq("rg_rdata", rdata0, 32'h0);
    tick;
    drive(32'h3FFC, 32'h5A5A5A5A, 4'hF, 32'h404, 1'b0);
    check_eq("rg_err_clear", {31'b0, rerr0}, 32'h0);
    check_eq("rg_no_trace", {31'b0, tv0}, 32'h0);
    tick;
    drive(32'h3FFC, 32'h0, 4'h0, 32'h0, 1'b1);
    check_eq("rg_top_rd", rdata0, 32'h5A5A5A5A);
    check_eq("rg_top_addr", taddr0, 32'h3FFC);
    tick;
    drive(32'h5000, 32'h0, 4'h0, 32'h0, 1'b0);
    check_eq("rg_rd_err", {31'b0, rerr0}, 32'h1);
    check_eq("rg_rd_zero", rdata0, 32'h0);
    tick;
    drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    check_eq("rg_rd_zero_l1", rdata1, 32'h0);
    check_eq("rg_err_pulse", {31'b0, rerr0}, 32'h0);

    // Overflow: 10 writes, ready low
    for (int i = 0; i < 10; i++) begin
      drive(32'(32'h100 + 4*i), 32'(32'hC0DE0000 + i), 4'hF, 32'(32'h2000 + 4*i), 1'b0);
      tick;
    end
    drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    check_eq("of_ovf", {31'b0, tovf0}, 32'h1);
    check_eq("of_drop", {16'b0, tdrop0}, 32'h2);
    check_eq("of_drop_l1", {16'b0, tdrop1}, 32'h2);
    check_eq("of_head_pc", tpc0, 32'h2000);
    tick;
    // Full with simultaneous push and pop
    drive(32'h200, 32'hFEED0010, 4'hF, 32'h3000, 1'b1);
    check_eq("fp_head", tdata0, 32'hC0DE0000);
    tick;
    for (int i = 0; i < 8; i++) begin
      drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
      check_eq("fp_valid", {31'b0, tv0}, 32'h1);
      check_eq("fp_pc", tpc0, (i < 7) ? 32'(32'h2000 + 4*(i+1)) : 32'h3000);
      check_eq("fp_addr", taddr0, (i < 7) ? 32'(32'h100 + 4*(i+1)) : 32'h200);
      check_eq("fp_data", tdata0, (i < 7) ? 32'(32'hC0DE0000 + i + 1) : 32'hFEED0010);
      tick;
    end
    drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    check_eq("fp_empty", {31'b0, tv0}, 32'h0);
    check_eq("fp_empty_l1", {31'b0, tv1}, 32'h0);
    check_eq("fp_drop", {16'b0, tdrop0}, 32'h2);
    check_eq("fp_ovf_l1", {31'b0, tovf1}, 32'h1);

    // Read latency
    drive(32'h20, 32'hDEADBEEF, 4'hF, 32'h500, 1'b1);
    check_eq("rl_pre", rdata0, 32'h0);
    tick;
    drive(32'h20, 32'h0, 4'h0, 32'h0, 1'b1);
    check_eq("rl_comb", rdata0, 32'hDEADBEEF);
    check_eq("rl_n1", rdata1, 32'h0);
    check_eq("rl_trace_l1", tpc1, 32'h500);
    tick;
    drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    check_eq("rl_n2", rdata1, 32'hDEADBEEF);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) begin
      drive(32'(32'h30 + 4*i), 32'(32'h77770000 + i), 4'hF, 32'(32'h600 + 4*i), 1'b0);
      tick;
    end
    drive(32'h30, 32'h0, 4'h0, 32'h0, 1'b0);
    check_eq("rs_pre_valid", {31'b0, tv0}, 32'h1);
    check_eq("rs_pre_rd", rdata0, 32'h77770000);
    reset = 1'b1;
    drive(32'h4000, 32'h0, 4'h0, 32'h0, 1'b1);
    check_eq("rs_range_err", {31'b0, rerr0}, 32'h0);
    tick;
    drive(32'h10, 32'h99999999, 4'hF, 32'h700, 1'b1);
    tick;
    reset = 1'b0;
    drive(32'h10, 32'h0, 4'h0, 32'h0, 1'b0);
    check_eq("rs_valid", {31'b0, tv0}, 32'h0);
    check_eq("rs_ovf", {31'b0, tovf0}, 32'h0);
    check_eq("rs_drop", {16'b0, tdrop0}, 32'h0);
    check_eq("rs_ovf_l1", {31'b0, tovf1}, 32'h0);
    check_eq("rs_rd_10", rdata0, 32'h0);
    check_eq("rs_rdreg", rdata1, 32'h0);
    tick;
    drive(32'h30, 32'h0, 4'h0, 32'h0, 1'b0);
    check_eq("rs_rd_30", rdata0, 32'h0);
    check_eq("rs_rd1_10", rdata1, 32'h0);
    drive(32'h20, 32'h0, 4'h0, 32'h0, 1'b0);
    check_eq("rs_rd_20", rdata0, 32'h0);
    drive(32'h3FFC, 32'h0, 4'h0, 32'h0, 1'b0);
    check_eq("rs_rd_3ffc", rdata0, 32'h0);
    tick;
    drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    check_eq("rs_rd1_3ffc", rdata1, 32'h0);
    check_eq("rs_valid_l1", {31'b0, tv1}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
